// File: rtl/sh4a_alu_arbiter.sv
// Round-robin share of the SH4A integer ALU between the execute pipe (port 0) and
// the address unit (port 1). Results return through credit-guarded per-port FIFOs.
module sh4a_alu_arbiter #(
    parameter int         TAG_W     = 4,
    parameter int         RSP_DEPTH = 2,
    parameter logic [5:0] NOP_OP    = 6'h3F
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_src1,
    input  logic [31:0]      req0_src2,
    input  logic [5:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_src1,
    input  logic [31:0]      req1_src2,
    input  logic [5:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_dest,
    output logic             rsp0_t,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_dest,
    output logic             rsp1_t,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    output logic [5:0]       alu_op,
    input  logic [31:0]      alu_dest,
    input  logic             alu_t
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 32 + 1 + TAG_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RSP_DEPTH);

    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       rsp_valid;
    logic [31:0]      req_src1 [2];
    logic [31:0]      req_src2 [2];
    logic [5:0]       req_op   [2];
    logic [TAG_W-1:0] req_tag  [2];
    logic [ENT_W-1:0] head     [2];
    logic             accept;
    logic             sel;

    logic             rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q [2], cnt_d [2];
    logic [31:0]      alu_src1_q, alu_src1_d;
    logic [31:0]      alu_src2_q, alu_src2_d;
    logic [5:0]       alu_op_q, alu_op_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_port_q, s1_port_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    logic             s2_port_q, s2_port_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic [ENT_W-1:0] mem_q [2][RSP_DEPTH];
    logic [ENT_W-1:0] mem_d [2][RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [2], wr_ptr_d [2];
    logic [PTR_W-1:0] rd_ptr_q [2], rd_ptr_d [2];
    logic [CNT_W-1:0] fill_q [2], fill_d [2];

    assign req_valid   = {req1_valid, req0_valid};
    assign rsp_ready   = {rsp1_ready, rsp0_ready};
    assign req_src1[0] = req0_src1;
    assign req_src1[1] = req1_src1;
    assign req_src2[0] = req0_src2;
    assign req_src2[1] = req1_src2;
    assign req_op[0]   = req0_op;
    assign req_op[1]   = req1_op;
    assign req_tag[0]  = req0_tag;
    assign req_tag[1]  = req1_tag;

    // Eligibility looks only at the registered credit count, so a pop frees a slot next cycle.
    assign eligible[0] = req_valid[0] && (cnt_q[0] < CNT_MAX);
    assign eligible[1] = req_valid[1] && (cnt_q[1] < CNT_MAX);

    always_comb begin
        grant = eligible;
        rr_d  = rr_q;
        if (&eligible) begin
            grant = rr_q ? 2'b01 : 2'b10;
            rr_d  = ~rr_q;
        end
    end

    assign accept     = |grant;
    assign sel        = grant[1];
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        alu_src1_d = alu_src1_q;
        alu_src2_d = alu_src2_q;
        alu_op_d   = NOP_OP;
        s1_valid_d = accept;
        s1_port_d  = sel;
        s1_tag_d   = req_tag[sel];
        if (accept) begin
            alu_src1_d = req_src1[sel];
            alu_src2_d = req_src2[sel];
            alu_op_d   = req_op[sel];
        end
        s2_valid_d = s1_valid_q;
        s2_port_d  = s1_port_q;
        s2_tag_d   = s1_tag_q;
    end

    assign rsp_valid[0] = (fill_q[0] != '0);
    assign rsp_valid[1] = (fill_q[1] != '0);

    // The ALU result for a stage-2 op is valid now; credits guarantee a free FIFO slot.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < 2; p++) begin
            push[p]     = s2_valid_q && (s2_port_q == 1'(p));
            pop[p]      = rsp_valid[p] && rsp_ready[p];
            wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(push[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(pop[p]);
            fill_d[p]   = fill_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
            cnt_d[p]    = cnt_q[p] + CNT_W'(grant[p]) - CNT_W'(pop[p]);
            if (push[p]) begin
                mem_d[p][wr_ptr_q[p]] = {alu_dest, alu_t, s2_tag_q};
            end
            head[p] = mem_q[p][rd_ptr_q[p]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= 1'b1;
            alu_src1_q <= '0;
            alu_src2_q <= '0;
            alu_op_q   <= NOP_OP;
            s1_valid_q <= 1'b0;
            s1_port_q  <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_port_q  <= 1'b0;
            s2_tag_q   <= '0;
            for (int p = 0; p < 2; p++) begin
                cnt_q[p]    <= '0;
                fill_q[p]   <= '0;
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                for (int i = 0; i < RSP_DEPTH; i++) begin
                    mem_q[p][i] <= '0;
                end
            end
        end else begin
            rr_q       <= rr_d;
            alu_src1_q <= alu_src1_d;
            alu_src2_q <= alu_src2_d;
            alu_op_q   <= alu_op_d;
            s1_valid_q <= s1_valid_d;
            s1_port_q  <= s1_port_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_port_q  <= s2_port_d;
            s2_tag_q   <= s2_tag_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

    assign alu_src1 = alu_src1_q;
    assign alu_src2 = alu_src2_q;
    assign alu_op   = alu_op_q;

    // An empty FIFO presents zeros rather than a stale head entry.
    assign rsp0_valid = rsp_valid[0];
    assign rsp0_dest  = rsp_valid[0] ? head[0][ENT_W-1 -: 32] : '0;
    assign rsp0_t     = rsp_valid[0] ? head[0][TAG_W] : 1'b0;
    assign rsp0_tag   = rsp_valid[0] ? head[0][TAG_W-1:0] : '0;
    assign rsp1_valid = rsp_valid[1];
    assign rsp1_dest  = rsp_valid[1] ? head[1][ENT_W-1 -: 32] : '0;
    assign rsp1_t     = rsp_valid[1] ? head[1][TAG_W] : 1'b0;
    assign rsp1_tag   = rsp_valid[1] ? head[1][TAG_W-1:0] : '0;

endmodule

// File: tb/tb_sh4a_alu_arbiter.sv
// Scoreboard bench for sh4a_alu_arbiter: drivers queue hand-computed results on
// every accepted request, a negedge monitor pops and compares each response.
module tb_sh4a_alu_arbiter;
    localparam int         TAG_W     = 4;
    localparam int         RSP_DEPTH = 2;
    localparam logic [5:0] NOP_OP    = 6'h3F;
    localparam logic [5:0] OP_ADD    = 6'h01;
    localparam logic [5:0] OP_SUB    = 6'h02;
    localparam logic [5:0] OP_AND    = 6'h03;
    localparam int         MAX_WAIT  = 40;

    typedef struct packed {
        logic [31:0]      dest;
        logic             t;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
    logic [5:0]       req0_op = '0, req1_op = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0]      rsp0_dest, rsp1_dest;
    logic             rsp0_t, rsp1_t;
    logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
    logic [31:0]      alu_src1, alu_src2;
    logic [5:0]       alu_op;
    logic [31:0]      alu_dest = '0;
    logic             alu_t = 1'b0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   acc_log[$];
    int   acc_cnt0 = 0, acc_cnt1 = 0, rsp_cnt0 = 0, rsp_cnt1 = 0;
    int   checks = 0, failures = 0;
    logic bg_done = 1'b0, wrap_done = 1'b0;

    always #5 clk = ~clk;

    sh4a_alu_arbiter #(.TAG_W(TAG_W), .RSP_DEPTH(RSP_DEPTH), .NOP_OP(NOP_OP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1),
        .req0_src2(req0_src2), .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1),
        .req1_src2(req1_src2), .req1_op(req1_op), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_dest(rsp0_dest),
        .rsp0_t(rsp0_t), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_dest(rsp1_dest),
        .rsp1_t(rsp1_t), .rsp1_tag(rsp1_tag),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
        .alu_dest(alu_dest), .alu_t(alu_t)
    );

    // ALU stand-in with one registered stage; NOP leaves dest and T untouched.
    always @(posedge clk) begin
        case (alu_op)
            OP_ADD: {alu_t, alu_dest} <= {1'b0, alu_src1} + {1'b0, alu_src2};
            OP_SUB: begin
                alu_dest <= alu_src1 - alu_src2;
                alu_t    <= (alu_src1 < alu_src2);
            end
            OP_AND: begin
                alu_dest <= alu_src1 & alu_src2;
                alu_t    <= ((alu_src1 & alu_src2) == 32'd0);
            end
            default: ;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic popAndCompare(input int p, input logic [31:0] d, input logic t, input logic [TAG_W-1:0] tag);
        exp_t e;
        if ((p == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
            checks++;
            failures++;
            $display("[TB] FAIL rsp%0d_unexpected actual=dest 0x%0h tag %0d expected=no response", p, d, tag);
            return;
        end
        if (p == 0) begin
            e = exp_q0.pop_front();
            rsp_cnt0++;
        end else begin
            e = exp_q1.pop_front();
            rsp_cnt1++;
        end
        checkOutput($sformatf("rsp%0d_dest", p), d, e.dest);
        checkOutput($sformatf("rsp%0d_t", p), 32'(t), 32'(e.t));
        checkOutput($sformatf("rsp%0d_tag", p), 32'(tag), 32'(e.tag));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp0_ready) popAndCompare(0, rsp0_dest, rsp0_t, rsp0_tag);
            if (rsp1_valid && rsp1_ready) popAndCompare(1, rsp1_dest, rsp1_t, rsp1_tag);
        end
    end

    // Holds the request until accepted, then queues its expected response.
    task automatic applyStimulus(input int port, input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [TAG_W-1:0] tag,
                                 input logic [31:0] exp_dest, input logic exp_tf, output int waits);
        exp_t e;
        logic rdy;
        e.dest = exp_dest;
        e.t    = exp_tf;
        e.tag  = tag;
        waits  = 0;
        rdy    = 1'b0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_src1 = a; req0_src2 = b; req0_tag = tag;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_src1 = a; req1_src2 = b; req1_tag = tag;
        end
        while (!rdy && waits < MAX_WAIT) begin
            @(negedge clk);
            rdy = (port == 0) ? req0_ready : req1_ready;
            if (!rdy) waits++;
        end
        if (!rdy) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout%0d actual=not accepted expected=accepted within %0d cycles", port, MAX_WAIT);
        end else begin
            acc_log.push_back(port);
            if (port == 0) begin
                exp_q0.push_back(e);
                acc_cnt0++;
                checkOutput("credit_limit0", 32'(exp_q0.size() > RSP_DEPTH), 32'd0);
            end else begin
                exp_q1.push_back(e);
                acc_cnt1++;
                checkOutput("credit_limit1", 32'(exp_q1.size() > RSP_DEPTH), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    task automatic checkResetValues(input string lbl);
        checkOutput({lbl, "_alu_op"}, 32'(alu_op), 32'(NOP_OP));
        checkOutput({lbl, "_alu_src1"}, alu_src1, 32'd0);
        checkOutput({lbl, "_alu_src2"}, alu_src2, 32'd0);
        checkOutput({lbl, "_rsp0_valid"}, 32'(rsp0_valid), 32'd0);
        checkOutput({lbl, "_rsp1_valid"}, 32'(rsp1_valid), 32'd0);
        checkOutput({lbl, "_rsp0_dest"}, rsp0_dest, 32'd0);
        checkOutput({lbl, "_rsp0_tag"}, 32'(rsp0_tag), 32'd0);
        checkOutput({lbl, "_rsp1_dest"}, rsp1_dest, 32'd0);
    endtask

    task automatic clearModel();
        exp_q0.delete();
        exp_q1.delete();
        acc_log.delete();
        acc_cnt0 = 0; acc_cnt1 = 0; rsp_cnt0 = 0; rsp_cnt1 = 0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        clearModel();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drainResponses(input string lbl);
        int n;
        n = 0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput({lbl, "_drain_q0"}, 32'(exp_q0.size()), 32'd0);
        checkOutput({lbl, "_drain_q1"}, 32'(exp_q1.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic singleOpCheck(input string lbl);
        int w;
        rsp0_ready = 1'b1;
        applyStimulus(0, OP_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, w);
        checkOutput({lbl, "_no_wait"}, 32'(w), 32'd0);
        @(negedge clk);
        checkOutput({lbl, "_alu_op_add"}, 32'(alu_op), 32'(OP_ADD));
        checkOutput({lbl, "_alu_src1"}, alu_src1, 32'd5);
        checkOutput({lbl, "_alu_src2"}, alu_src2, 32'd7);
        checkOutput({lbl, "_rsp_early"}, 32'(rsp0_valid), 32'd0);
        @(negedge clk);
        checkOutput({lbl, "_alu_op_nop"}, 32'(alu_op), 32'(NOP_OP));
        checkOutput({lbl, "_rsp_e1"}, 32'(rsp0_valid), 32'd0);
        @(negedge clk);
        checkOutput({lbl, "_rsp_e2"}, 32'(rsp0_valid), 32'd1);
        @(negedge clk);
        checkOutput({lbl, "_rsp_once"}, 32'(rsp0_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int n;
        #1 rst_n = 1'b0;
        #2 checkResetValues("por");
        doReset();

        singleOpCheck("single");

        // Contention: both ports stream four ops each from a fresh reset.
        doReset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        fork
            begin
                int wa;
                applyStimulus(0, OP_ADD, 32'd1, 32'd2, 4'd1, 32'd3, 1'b0, wa);
                applyStimulus(0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 4'd2, 32'd0, 1'b1, wa);
                applyStimulus(0, OP_SUB, 32'd10, 32'd3, 4'd3, 32'd7, 1'b0, wa);
                applyStimulus(0, OP_AND, 32'hF0, 32'h3C, 4'd4, 32'h30, 1'b0, wa);
            end
            begin
                int wb;
                applyStimulus(1, OP_SUB, 32'd3, 32'd5, 4'd9, 32'hFFFF_FFFE, 1'b1, wb);
                applyStimulus(1, OP_ADD, 32'd100, 32'd200, 4'hA, 32'd300, 1'b0, wb);
                applyStimulus(1, OP_AND, 32'h0F, 32'hF0, 4'hB, 32'd0, 1'b1, wb);
                applyStimulus(1, OP_SUB, 32'd50, 32'd50, 4'hC, 32'd0, 1'b0, wb);
            end
        join
        drainResponses("rr");
        checkOutput("rr_grant_count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < acc_log.size() && i < 8; i++) begin
            checkOutput($sformatf("rr_grant%0d", i), 32'(acc_log[i]), 32'(i % 2));
        end

        // Back-pressure: port 1 responses stalled, port 0 keeps going.
        doReset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b0;
        bg_done = 1'b0;
        fork
            begin
                int wa;
                applyStimulus(0, OP_ADD, 32'd1000, 32'd1, 4'd0, 32'd1001, 1'b0, wa);
                applyStimulus(0, OP_ADD, 32'd2, 32'd2, 4'd1, 32'd4, 1'b0, wa);
                applyStimulus(0, OP_SUB, 32'd9, 32'd4, 4'd2, 32'd5, 1'b0, wa);
                applyStimulus(0, OP_AND, 32'hFF, 32'h0F, 4'd3, 32'h0F, 1'b0, wa);
                applyStimulus(0, OP_SUB, 32'd0, 32'd1, 4'd4, 32'hFFFF_FFFF, 1'b1, wa);
                applyStimulus(0, OP_ADD, 32'h8000_0000, 32'h8000_0000, 4'd5, 32'd0, 1'b1, wa);
            end
            begin
                int wb;
                applyStimulus(1, OP_ADD, 32'd10, 32'd20, 4'd1, 32'd30, 1'b0, wb);
                applyStimulus(1, OP_SUB, 32'd7, 32'd2, 4'd2, 32'd5, 1'b0, wb);
            end
        join
        checkOutput("bp_port0_accepts", 32'(acc_cnt0), 32'd6);
        checkOutput("bp_port1_accepts", 32'(acc_cnt1), 32'd2);
        fork
            begin
                int wb;
                applyStimulus(1, OP_ADD, 32'd3, 32'd4, 4'd3, 32'd7, 1'b0, wb);
                applyStimulus(1, OP_SUB, 32'd20, 32'd5, 4'd4, 32'd15, 1'b0, wb);
                bg_done = 1'b1;
            end
        join_none
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_req1_blocked", 32'(req1_ready), 32'd0);
        end
        checkOutput("bp_port1_accepts_held", 32'(acc_cnt1), 32'd2);
        @(posedge clk);
        #1 rsp1_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_pop_valid", 32'(rsp1_valid), 32'd1);
        checkOutput("bp_pop_cycle_blocked", 32'(req1_ready), 32'd0);
        @(negedge clk);
        checkOutput("bp_reaccept", 32'(req1_ready), 32'd1);
        n = 0;
        while (!bg_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_bg_done", 32'(bg_done), 32'd1);
        drainResponses("bp");
        checkOutput("bp_port1_rsp_count", 32'(rsp_cnt1), 32'd4);

        // Wrap: ten subtracts on port 0 with a toggling response ready.
        doReset();
        rsp0_ready = 1'b1;
        wrap_done = 1'b0;
        fork
            begin
                int wa;
                for (int i = 0; i < 10; i++) begin
                    applyStimulus(0, OP_SUB, 32'(i + 100), 32'(i), 4'(i), 32'd100, 1'b0, wa);
                end
                wrap_done = 1'b1;
            end
            begin
                while (!wrap_done) begin
                    @(posedge clk);
                    #1 rsp0_ready = ~rsp0_ready;
                end
            end
        join
        drainResponses("wrap");
        checkOutput("wrap_rsp_count", 32'(rsp_cnt0), 32'd10);

        // Credits back at zero: two ops go straight in; then reset while they are in flight.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        applyStimulus(0, OP_ADD, 32'd1, 32'd1, 4'd5, 32'd2, 1'b0, w);
        checkOutput("cnt0_zero_first", 32'(w), 32'd0);
        applyStimulus(0, OP_ADD, 32'd2, 32'd2, 4'd6, 32'd4, 1'b0, w);
        checkOutput("cnt0_zero_second", 32'(w), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        clearModel();
        #1 checkResetValues("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) n++;
        end
        checkOutput("midrst_no_stale_rsp", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        singleOpCheck("post_rst");
        drainResponses("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog actual=still running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
